// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vram_pkg
// Purpose : Shared widths, VRAM depth, access-owner tags and fill FSM states
//           for the VRAM arbiter slice.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package vram_pkg;

  localparam int DEF_HPOS_W = 7;     // 128 columns
  localparam int DEF_VPOS_W = 6;     // 64 rows
  localparam int DEF_PIX_W  = 2;     // bits per pixel
  localparam int VRAM_DEPTH = 8192;  // 128 * 64 locations

  // Consumer of the read issued in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic [0:0] {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_e;

endpackage : vram_pkg
`default_nettype wire

// File: rtl/vram_fill_seq.sv
`default_nettype none
// ============================================================================
// Module  : vram_fill_seq
// Purpose : Background fill engine. Walks every VRAM address once, writing a
//           latched pixel value, advancing only in cycles it owns the port.
// Ports   : clk_i/reset_i   clock, asynchronous active-high reset
//           start_i         pulse: (re)start the fill from address 0
//           value_i         fill value, sampled with start_i
//           advance_i       this cycle's write was issued; step the counter
//           busy_o          fill in progress
//           done_o          one-cycle pulse after the final write
//           addr_o/value_o  address and data of the pending fill write
// Revision: 1.0 - initial release
// ============================================================================
module vram_fill_seq
  import vram_pkg::*;
#(
  parameter int ADDR_W = DEF_HPOS_W + DEF_VPOS_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [PIX_W-1:0]  value_i,
  input  logic              advance_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [PIX_W-1:0]  value_o
);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0]  val_q, val_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= FILL_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    done_d  = 1'b0;
    if (start_i) begin
      // A start while running abandons the current pass silently.
      state_d = FILL_RUN;
      cnt_d   = '0;
      val_d   = value_i;
    end else if ((state_q == FILL_RUN) && advance_i) begin
      if (cnt_q == '1) begin
        state_d = FILL_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  assign busy_o  = (state_q == FILL_RUN);
  assign done_o  = done_q;
  assign addr_o  = cnt_q;
  assign value_o = val_q;

endmodule : vram_fill_seq
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vram_arbiter
// Purpose : Shares a single-port, synchronous-read VRAM between display
//           scanout, the CPU and the fill engine. One access per cycle,
//           fixed priority display > fill > CPU.
// Ports   : clk_i/reset_i          clock, asynchronous active-high reset
//           disp_*                 scanout read request and returned pixel
//           cpu_*                  CPU req/ack read/write port
//           fill_*                 fill start/value and busy/done status
//           vram_*                 VRAM macro address/data/write-enable/read
// Revision: 1.0 - initial release
// ============================================================================
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int HPOS_W = DEF_HPOS_W,
  parameter int VPOS_W = DEF_VPOS_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     disp_req_i,
  input  logic [HPOS_W-1:0]        disp_hpos_i,
  input  logic [VPOS_W-1:0]        disp_vpos_i,
  output logic                     disp_valid_o,
  output logic [PIX_W-1:0]         disp_pixel_o,
  input  logic                     cpu_req_i,
  input  logic                     cpu_we_i,
  input  logic [HPOS_W-1:0]        cpu_hpos_i,
  input  logic [VPOS_W-1:0]        cpu_vpos_i,
  input  logic [PIX_W-1:0]         cpu_pixeli_i,
  output logic [PIX_W-1:0]         cpu_pixelo_o,
  output logic                     cpu_ack_o,
  input  logic                     fill_start_i,
  input  logic [PIX_W-1:0]         fill_value_i,
  output logic                     fill_busy_o,
  output logic                     fill_done_o,
  output logic [HPOS_W+VPOS_W-1:0] vram_addr_o,
  output logic [PIX_W-1:0]         vram_din_o,
  output logic                     vram_we_o,
  input  logic [PIX_W-1:0]         vram_dout_i
);

  localparam int ADDR_W = HPOS_W + VPOS_W;

  logic              fill_busy;
  logic              fill_adv;
  logic              cpu_gnt;
  logic [ADDR_W-1:0] fill_addr;
  logic [PIX_W-1:0]  fill_val;
  owner_e            tag_q, tag_d;
  logic              disp_valid_q;
  logic              cpu_ack_q;

  vram_fill_seq #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_fill (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (fill_start_i),
    .value_i   (fill_value_i),
    .advance_i (fill_adv),
    .busy_o    (fill_busy),
    .done_o    (fill_done_o),
    .addr_o    (fill_addr),
    .value_o   (fill_val)
  );

  // Fill only steps when display leaves the slot free. The CPU additionally
  // waits out the whole fill and its own ack cycle (one access outstanding).
  assign fill_adv = fill_busy & ~disp_req_i;
  assign cpu_gnt  = cpu_req_i & ~disp_req_i & ~fill_busy & ~cpu_ack_q;

  always_comb begin
    vram_addr_o = '0;
    vram_din_o  = '0;
    vram_we_o   = 1'b0;
    tag_d       = OWN_NONE;
    // Port is kept quiet while reset is held.
    if (!reset_i) begin
      if (disp_req_i) begin
        vram_addr_o = {disp_vpos_i, disp_hpos_i};
        tag_d       = OWN_DISP;
      end else if (fill_adv) begin
        vram_addr_o = fill_addr;
        vram_din_o  = fill_val;
        vram_we_o   = 1'b1;
      end else if (cpu_gnt) begin
        vram_addr_o = {cpu_vpos_i, cpu_hpos_i};
        vram_din_o  = cpu_pixeli_i;
        vram_we_o   = cpu_we_i;
        tag_d       = cpu_we_i ? OWN_NONE : OWN_CPU;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag_q        <= OWN_NONE;
      disp_valid_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      disp_valid_q <= disp_req_i;
      cpu_ack_q    <= cpu_gnt;
    end
  end

  // Read data arrives one cycle after issue; the tag steers it to one reader.
  assign disp_pixel_o = (tag_q == OWN_DISP) ? vram_dout_i : '0;
  assign cpu_pixelo_o = (tag_q == OWN_CPU)  ? vram_dout_i : '0;
  assign disp_valid_o = disp_valid_q;
  assign cpu_ack_o    = cpu_ack_q;
  assign fill_busy_o  = fill_busy;

endmodule : vram_arbiter
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_arbiter
// Purpose : Directed self-checking bench for vram_arbiter with a behavioural
//           synchronous-read VRAM model.
// Ports   : none (testbench top)
// Revision: 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        disp_req;
  logic [6:0]  disp_hpos;
  logic [5:0]  disp_vpos;
  logic        disp_valid;
  logic [1:0]  disp_pixel;
  logic        cpu_req;
  logic        cpu_we;
  logic [6:0]  cpu_hpos;
  logic [5:0]  cpu_vpos;
  logic [1:0]  cpu_pixeli;
  logic [1:0]  cpu_pixelo;
  logic        cpu_ack;
  logic        fill_start;
  logic [1:0]  fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic [12:0] vram_addr;
  logic [1:0]  vram_din;
  logic        vram_we;
  logic [1:0]  vram_dout;

  logic [1:0]  mem [0:8191];

  int nvec;
  int nerr;

  vram_arbiter dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .disp_req_i   (disp_req),
    .disp_hpos_i  (disp_hpos),
    .disp_vpos_i  (disp_vpos),
    .disp_valid_o (disp_valid),
    .disp_pixel_o (disp_pixel),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_hpos_i   (cpu_hpos),
    .cpu_vpos_i   (cpu_vpos),
    .cpu_pixeli_i (cpu_pixeli),
    .cpu_pixelo_o (cpu_pixelo),
    .cpu_ack_o    (cpu_ack),
    .fill_start_i (fill_start),
    .fill_value_i (fill_value),
    .fill_busy_o  (fill_busy),
    .fill_done_o  (fill_done),
    .vram_addr_o  (vram_addr),
    .vram_din_o   (vram_din),
    .vram_we_o    (vram_we),
    .vram_dout_i  (vram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous-read VRAM: read-before-write, one cycle latency.
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_din;
    vram_dout <= mem[vram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    disp_req = 1'b1; disp_hpos = 7'd0; disp_vpos = 6'd0;
    repeat (3) tick();
    nvec++;
    if (disp_valid !== 1'b0 || cpu_ack !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      nerr++;
      $display("FAIL reset_status: valid=%b ack=%b busy=%b done=%b, required all 0",
               disp_valid, cpu_ack, fill_busy, fill_done);
    end
    nvec++;
    if (vram_we !== 1'b0 || vram_addr !== 13'd0 || vram_din !== 2'd0 ||
        disp_pixel !== 2'd0 || cpu_pixelo !== 2'd0) begin
      nerr++;
      $display("FAIL reset_port: we=%b addr=%h din=%h dpix=%h cpix=%h, required all 0",
               vram_we, vram_addr, vram_din, disp_pixel, cpu_pixelo);
    end
    reset = 1'b0;
    #1;
    nvec++;
    if (disp_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_release_c1: disp_valid=%b, required 0", disp_valid);
    end
    tick();
    nvec++;
    if (disp_valid !== 1'b1) begin
      nerr++; $display("FAIL reset_release_c2: disp_valid=%b, required 1", disp_valid);
    end
    disp_req = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_hpos = 7'd5; cpu_vpos = 6'd3; cpu_pixeli = 2'd2;
    #1;
    nvec++;
    if (vram_addr !== 13'h185 || vram_we !== 1'b1 || vram_din !== 2'd2 || cpu_ack !== 1'b0) begin
      nerr++;
      $display("FAIL cpu_wr_issue: addr=%h we=%b din=%h ack=%b, required 185 1 2 0",
               vram_addr, vram_we, vram_din, cpu_ack);
    end
    tick();
    nvec++;
    if (cpu_ack !== 1'b1) begin
      nerr++; $display("FAIL cpu_wr_ack: cpu_ack=%b, required 1", cpu_ack);
    end
    cpu_we = 1'b0;
    #1;
    nvec++;
    if (vram_we !== 1'b0 && vram_addr === 13'h185) begin
      nerr++; $display("FAIL cpu_ack_spacing: we=%b during ack cycle, required 0", vram_we);
    end
    tick();
    // The held request was re-issued as a read after the ack cycle.
    nvec++;
    if (cpu_ack !== 1'b0) begin
      nerr++; $display("FAIL cpu_gap: cpu_ack=%b, required 0", cpu_ack);
    end
    #1;
    nvec++;
    if (vram_addr !== 13'h185 || vram_we !== 1'b0) begin
      nerr++; $display("FAIL cpu_rd_issue: addr=%h we=%b, required 185 0", vram_addr, vram_we);
    end
    tick();
    nvec++;
    if (cpu_ack !== 1'b1 || cpu_pixelo !== 2'd2) begin
      nerr++; $display("FAIL cpu_rd_data: ack=%b pixelo=%h, required 1 2", cpu_ack, cpu_pixelo);
    end
    cpu_req = 1'b0;
    tick();
    nvec++;
    if (cpu_ack !== 1'b0) begin
      nerr++; $display("FAIL cpu_idle: cpu_ack=%b, required 0", cpu_ack);
    end
  endtask

  task automatic test_disp_blocks_cpu();
    int nvalid;
    int early;
    nvalid = 0; early = 0;
    disp_req = 1'b1; disp_hpos = 7'd5; disp_vpos = 6'd3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd5; cpu_vpos = 6'd3;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ack) early++;
      if (disp_valid && disp_pixel === 2'd2) nvalid++;
      if (i == 19) disp_req = 1'b0;
    end
    nvec++;
    if (early != 0) begin
      nerr++; $display("FAIL disp_block_ack: %0d acks during display burst, required 0", early);
    end
    nvec++;
    if (nvalid != 20) begin
      nerr++; $display("FAIL disp_burst_valid: %0d good beats, required 20", nvalid);
    end
    tick();
    nvec++;
    if (cpu_ack !== 1'b1 || cpu_pixelo !== 2'd2 || disp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL disp_then_cpu: ack=%b pixelo=%h valid=%b, required 1 2 0",
               cpu_ack, cpu_pixelo, disp_valid);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    int exp, busy, done, n, seq_err, bad;
    logic early, got_ack;
    logic [1:0] ack_pix;
    exp = 0; busy = 0; done = 0; n = 0; seq_err = 0; bad = 0;
    early = 1'b0; got_ack = 1'b0; ack_pix = 2'd0;
    fill_start = 1'b1; fill_value = 2'd3;
    #1;
    nvec++;
    if (fill_busy !== 1'b0) begin
      nerr++; $display("FAIL fill_start_cycle: busy=%b, required 0", fill_busy);
    end
    tick();
    fill_start = 1'b0; fill_value = 2'd0;
    nvec++;
    if (fill_busy !== 1'b1) begin
      nerr++; $display("FAIL fill_busy_rise: busy=%b, required 1", fill_busy);
    end
    while (!got_ack && n < 9000) begin
      if (fill_done) done++;
      if (cpu_ack) begin
        got_ack = 1'b1; ack_pix = cpu_pixelo;
        if (done == 0) early = 1'b1;
        cpu_req = 1'b0;
      end
      if (busy == 4000) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_hpos = 7'd5; cpu_vpos = 6'd3;
      end
      #1;
      if (fill_busy) begin
        if (vram_addr !== exp[12:0] || vram_we !== 1'b1 || vram_din !== 2'd3) seq_err++;
        exp++; busy++;
      end
      tick();
      n++;
    end
    cpu_req = 1'b0;
    nvec++;
    if (busy != 8192) begin
      nerr++; $display("FAIL fill_length: busy %0d cycles, required 8192", busy);
    end
    nvec++;
    if (done != 1) begin
      nerr++; $display("FAIL fill_done_count: %0d pulses, required 1", done);
    end
    nvec++;
    if (seq_err != 0) begin
      nerr++; $display("FAIL fill_sequence: %0d bad write cycles, required 0", seq_err);
    end
    nvec++;
    if (!got_ack || early) begin
      nerr++; $display("FAIL fill_cpu_block: got_ack=%b early=%b, required 1 0", got_ack, early);
    end
    nvec++;
    if (ack_pix !== 2'd3) begin
      nerr++; $display("FAIL fill_cpu_read: pixelo=%h, required 3", ack_pix);
    end
    for (int a = 0; a < 8192; a++) if (mem[a] !== 2'd3) bad++;
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL fill_contents3: %0d locations not 3, required 0", bad);
    end
    tick();
  endtask

  task automatic test_fill_with_display();
    int exp, busy, nd, i, bad, cbad;
    logic prev, done;
    exp = 0; busy = 0; nd = 0; i = 0; bad = 0; cbad = 0;
    prev = 1'b0; done = 1'b0;
    disp_hpos = 7'd127; disp_vpos = 6'd63;
    fill_start = 1'b1; fill_value = 2'd2;
    tick();
    fill_start = 1'b0;
    while (!done && i < 12000) begin
      if (disp_valid !== prev) bad++;
      if (disp_valid && (disp_pixel !== 2'd3 || cpu_pixelo !== 2'd0 || cpu_ack !== 1'b0)) bad++;
      if (fill_done) done = 1'b1;
      disp_req = ((i % 4) == 3);
      #1;
      if (fill_busy) begin
        busy++;
        if (disp_req) begin
          nd++;
          if (vram_we !== 1'b0 || vram_addr !== 13'h1FFF) bad++;
        end else begin
          if (vram_addr !== exp[12:0] || vram_we !== 1'b1 || vram_din !== 2'd2) bad++;
          exp++;
        end
      end
      prev = disp_req;
      tick();
      i++;
    end
    disp_req = 1'b0;
    nvec++;
    if (!done || nd != 2730 || busy != 10922) begin
      nerr++;
      $display("FAIL fill_disp_length: done=%b disp=%0d busy=%0d, required 1 2730 10922",
               done, nd, busy);
    end
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL fill_disp_beats: %0d bad cycles, required 0", bad);
    end
    for (int a = 0; a < 8192; a++) if (mem[a] !== 2'd2) cbad++;
    nvec++;
    if (cbad != 0) begin
      nerr++; $display("FAIL fill_contents2: %0d locations not 2, required 0", cbad);
    end
    tick();
  endtask

  task automatic test_fill_restart_and_reset();
    int seq_err, done, busy, exp, bad;
    seq_err = 0; done = 0; busy = 0; exp = 0; bad = 0;
    fill_start = 1'b1; fill_value = 2'd0;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (fill_done) done++;
      #1;
      if (vram_addr !== k[12:0] || vram_din !== 2'd0) seq_err++;
      tick();
    end
    fill_start = 1'b1; fill_value = 2'd1;
    #1;
    nvec++;
    if (vram_addr !== 13'd100) begin
      nerr++; $display("FAIL restart_point: addr=%h, required 064", vram_addr);
    end
    tick();
    fill_start = 1'b0; fill_value = 2'd0;
    #1;
    nvec++;
    if (vram_addr !== 13'd0 || vram_din !== 2'd1 || vram_we !== 1'b1) begin
      nerr++;
      $display("FAIL restart_zero: addr=%h din=%h we=%b, required 0000 1 1",
               vram_addr, vram_din, vram_we);
    end
    for (int n = 0; n < 8200; n++) begin
      if (fill_done) done++;
      #1;
      if (fill_busy) begin
        if (vram_addr !== exp[12:0] || vram_din !== 2'd1) seq_err++;
        exp++; busy++;
      end
      tick();
    end
    nvec++;
    if (busy != 8192 || done != 1 || seq_err != 0) begin
      nerr++;
      $display("FAIL restart_fill: busy=%0d done=%0d seq_err=%0d, required 8192 1 0",
               busy, done, seq_err);
    end
    for (int a = 0; a < 8192; a++) if (mem[a] !== 2'd1) bad++;
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL restart_contents: %0d locations not 1, required 0", bad);
    end
    fill_start = 1'b1; fill_value = 2'd3;
    tick();
    fill_start = 1'b0;
    repeat (50) tick();
    nvec++;
    if (fill_busy !== 1'b1) begin
      nerr++; $display("FAIL midfill_busy: busy=%b, required 1", fill_busy);
    end
    #2;
    reset = 1'b1;
    #1;
    nvec++;
    if (fill_busy !== 1'b0 || vram_we !== 1'b0) begin
      nerr++; $display("FAIL async_reset: busy=%b we=%b, required 0 0", fill_busy, vram_we);
    end
    tick();
    reset = 1'b0;
    repeat (2) tick();
    nvec++;
    if (fill_busy !== 1'b0 || fill_done !== 1'b0 || cpu_ack !== 1'b0) begin
      nerr++;
      $display("FAIL after_reset: busy=%b done=%b ack=%b, required 0 0 0",
               fill_busy, fill_done, cpu_ack);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0; nerr = 0;
    for (int a = 0; a < 8192; a++) mem[a] = 2'd0;
    vram_dout = 2'd0;
    reset = 1'b1;
    disp_req = 1'b0; disp_hpos = 7'd0; disp_vpos = 6'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_hpos = 7'd0; cpu_vpos = 6'd0; cpu_pixeli = 2'd0;
    fill_start = 1'b0; fill_value = 2'd0;
    test_reset();
    test_cpu_write_read();
    test_disp_blocks_cpu();
    test_fill();
    test_fill_with_display();
    test_fill_restart_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_vram_arbiter
`default_nettype wire
